regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 152 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: exception / load / ALU write ports,
// anti-starvation boost for the ALU, and a pending-load scoreboard.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   exc_req, exc_wd                 exception write (never refused)
//   ld_valid/ld_ready, ld_rc, ld_wd load-return write handshake
//   alu_valid/alu_ready, alu_rc, alu_wd  ALU write handshake
//   ld_issue, ld_issue_rc           load issued, marks rc pending
//   ra, rb / haz_a, haz_b           decode read addresses / pending flags
//   werf, wa, wd                    registered register-file write port
module regfile_wb_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int XP_REG     = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_req,
    input  logic [31:0] exc_wd,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rc,
    input  logic [31:0] ld_wd,
    output logic        ld_ready,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rc,
    input  logic [31:0] alu_wd,
    output logic        alu_ready,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_rc,
    input  logic [4:0]  ra,
    input  logic [4:0]  rb,
    output logic        haz_a,
    output logic        haz_b,
    output logic        werf,
    output logic [4:0]  wa,
    output logic [31:0] wd
);

    typedef enum logic {NORM, BOOST} state_t;

    localparam logic [3:0] SMAX  = 4'(STARVE_MAX);
    localparam logic [4:0] XP_RC = 5'(XP_REG);

    state_t      state, state_nx;
    logic [3:0]  starve_cnt, cnt_nx;
    logic [31:0] busy, busy_nx;
    logic        run_q;
    logic        exc_g;
    logic        grant;
    logic [4:0]  rc_w;
    logic [31:0] wd_w;

    // run_q stays low for the first cycle after reset release so that
    // no grant can be issued at the first edge after rst_n rises.
    assign exc_g = exc_req && run_q;

    always_comb begin
        ld_ready  = 1'b0;
        alu_ready = 1'b0;
        if (run_q && !exc_req) begin
            if (state == BOOST) begin
                alu_ready = alu_valid;
                ld_ready  = ld_valid && !alu_valid;
            end else begin
                ld_ready  = ld_valid;
                alu_ready = alu_valid && !ld_valid;
            end
        end
    end

    always_comb begin
        grant = 1'b1;
        rc_w  = 5'd0;
        wd_w  = 32'd0;
        unique case (1'b1)
            exc_g: begin
                rc_w = XP_RC;
                wd_w = exc_wd;
            end
            ld_ready: begin
                rc_w = ld_rc;
                wd_w = ld_wd;
            end
            alu_ready: begin
                rc_w = alu_rc;
                wd_w = alu_wd;
            end
            default: grant = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = starve_cnt;
        case (state)
            NORM: begin
                if (alu_valid && !alu_ready) begin
                    cnt_nx = starve_cnt + 4'd1;
                    if (cnt_nx == SMAX) state_nx = BOOST;
                end else begin
                    cnt_nx = 4'd0;
                end
            end
            BOOST: begin
                if (alu_ready || !alu_valid) begin
                    state_nx = NORM;
                    cnt_nx   = 4'd0;
                end
            end
            default: begin
                state_nx = NORM;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // Clear for the granted load first, then set for a new issue, so an
    // issue to the same register in the same cycle keeps it pending.
    always_comb begin
        busy_nx = busy;
        if (ld_ready) busy_nx[ld_rc] = 1'b0;
        if (ld_issue && ld_issue_rc != 5'd31)
            busy_nx[ld_issue_rc] = 1'b1;
        busy_nx[31] = 1'b0;
    end

    assign haz_a = busy[ra];
    assign haz_b = busy[rb];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= NORM;
            starve_cnt <= 4'd0;
            busy       <= 32'd0;
            run_q      <= 1'b0;
            werf       <= 1'b0;
            wa         <= 5'd0;
            wd         <= 32'd0;
        end else begin
            state      <= state_nx;
            starve_cnt <= cnt_nx;
            busy       <= busy_nx;
            run_q      <= 1'b1;
            werf       <= grant && (rc_w != 5'd31);
            if (grant) begin
                wa <= rc_w;
                wd <= wd_w;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: table of single-cycle grants
// plus hand-written starvation, scoreboard and reset sequences.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_req;
    logic [31:0] exc_wd;
    logic        ld_valid;
    logic [4:0]  ld_rc;
    logic [31:0] ld_wd;
    logic        ld_ready;
    logic        alu_valid;
    logic [4:0]  alu_rc;
    logic [31:0] alu_wd;
    logic        alu_ready;
    logic        ld_issue;
    logic [4:0]  ld_issue_rc;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        haz_a;
    logic        haz_b;
    logic        werf;
    logic [4:0]  wa;
    logic [31:0] wd;

    int checks   = 0;
    int failures = 0;

    regfile_wb_arbiter #(.STARVE_MAX(4), .XP_REG(30)) dut (
        .clk(clk), .rst_n(rst_n),
        .exc_req(exc_req), .exc_wd(exc_wd),
        .ld_valid(ld_valid), .ld_rc(ld_rc), .ld_wd(ld_wd),
        .ld_ready(ld_ready),
        .alu_valid(alu_valid), .alu_rc(alu_rc), .alu_wd(alu_wd),
        .alu_ready(alu_ready),
        .ld_issue(ld_issue), .ld_issue_rc(ld_issue_rc),
        .ra(ra), .rb(rb), .haz_a(haz_a), .haz_b(haz_b),
        .werf(werf), .wa(wa), .wd(wd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        exc;
        logic [31:0] exc_wd;
        logic        ldv;
        logic [4:0]  ld_rc;
        logic [31:0] ld_wd;
        logic        aluv;
        logic [4:0]  alu_rc;
        logic [31:0] alu_wd;
        logic        e_ldr;
        logic        e_alur;
        logic        e_werf;
        logic        chk_addr;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exc_req   = 1'b0;
        ld_valid  = 1'b0;
        alu_valid = 1'b0;
        ld_issue  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{0, 0, 0, 0, 0, 1, 5, 32'h11, 0, 1, 1, 1, 5, 32'h11};
        vecs[1] = '{1, 32'h400, 1, 2, 32'h22, 1, 3, 32'h33,
                    0, 0, 1, 1, 30, 32'h400};
        vecs[2] = '{0, 0, 1, 9, 32'hdead, 0, 0, 0,
                    1, 0, 1, 1, 9, 32'hdead};
        vecs[3] = '{0, 0, 1, 2, 32'h22, 1, 3, 32'h33,
                    1, 0, 1, 1, 2, 32'h22};
        vecs[4] = '{0, 0, 0, 0, 0, 1, 31, 32'h77, 0, 1, 0, 0, 0, 0};
        vecs[5] = '{0, 0, 1, 31, 32'h88, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        vecs[6] = '{1, 32'h1234, 0, 0, 0, 0, 0, 0,
                    0, 0, 1, 1, 30, 32'h1234};
        vecs[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 30, 32'h1234};

        rst_n = 1'b0;
        idle();
        exc_wd = 0; ld_rc = 0; ld_wd = 0;
        alu_rc = 0; alu_wd = 0; ld_issue_rc = 0;
        ra = 0; rb = 0;
        #1;
        check("rst_werf", werf, 0);
        check("rst_wa", wa, 0);
        check("rst_wd", wd, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_alu_ready", alu_ready, 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 8; i++) begin
            exc_req   = vecs[i].exc;
            exc_wd    = vecs[i].exc_wd;
            ld_valid  = vecs[i].ldv;
            ld_rc     = vecs[i].ld_rc;
            ld_wd     = vecs[i].ld_wd;
            alu_valid = vecs[i].aluv;
            alu_rc    = vecs[i].alu_rc;
            alu_wd    = vecs[i].alu_wd;
            #1;
            check($sformatf("v%0d_ld_ready", i), ld_ready, vecs[i].e_ldr);
            check($sformatf("v%0d_alu_ready", i), alu_ready,
                  vecs[i].e_alur);
            step();
            idle();
            check($sformatf("v%0d_werf", i), werf, vecs[i].e_werf);
            if (vecs[i].chk_addr) begin
                check($sformatf("v%0d_wa", i), wa, vecs[i].e_wa);
                check($sformatf("v%0d_wd", i), wd, vecs[i].e_wd);
            end
        end
        step();

        // Starvation: L L L L then boosted ALU, then load again.
        ld_valid  = 1'b1;
        ld_rc     = 5'd4;
        alu_valid = 1'b1;
        alu_rc    = 5'd6;
        alu_wd    = 32'h600;
        for (int c = 0; c < 6; c++) begin
            logic ae;
            ae = (c == 4);
            ld_wd = 32'h100 + c;
            #1;
            check($sformatf("st%0d_ld_ready", c), ld_ready, !ae);
            check($sformatf("st%0d_alu_ready", c), alu_ready, ae);
            @(posedge clk);
            #1;
            check($sformatf("st%0d_werf", c), werf, 1);
            check($sformatf("st%0d_wa", c), wa, ae ? 6 : 4);
            check($sformatf("st%0d_wd", c), wd,
                  ae ? 32'h600 : 32'h100 + c);
        end
        idle();
        step();

        // Boost abandoned when alu_valid drops.
        ld_valid  = 1'b1;
        alu_valid = 1'b1;
        repeat (4) step();
        alu_valid = 1'b0;
        #1;
        check("drop_ld_ready", ld_ready, 1);
        step();
        alu_valid = 1'b1;
        #1;
        check("drop_norm_ld_ready", ld_ready, 1);
        check("drop_norm_alu_ready", alu_ready, 0);
        idle();
        step();

        // Scoreboard: issue rc7, hazard until the edge after its grant.
        ra          = 5'd7;
        rb          = 5'd31;
        ld_issue    = 1'b1;
        ld_issue_rc = 5'd7;
        #1;
        check("haz_before_edge", haz_a, 0);
        step();
        ld_issue = 1'b0;
        check("haz_set", haz_a, 1);
        step();
        check("haz_hold", haz_a, 1);
        ld_valid = 1'b1;
        ld_rc    = 5'd7;
        ld_wd    = 32'h70;
        #1;
        check("haz_grant_ld_ready", ld_ready, 1);
        check("haz_grant_cycle", haz_a, 1);
        step();
        ld_valid = 1'b0;
        check("haz_cleared", haz_a, 0);
        ld_issue    = 1'b1;
        ld_issue_rc = 5'd31;
        step();
        ld_issue = 1'b0;
        check("haz_r31", haz_b, 0);

        // Same-cycle issue and grant of rc8: set wins.
        rb          = 5'd8;
        ld_issue    = 1'b1;
        ld_issue_rc = 5'd8;
        step();
        ld_valid = 1'b1;
        ld_rc    = 5'd8;
        step();
        ld_issue = 1'b0;
        check("haz_set_wins", haz_b, 1);
        step();
        ld_valid = 1'b0;
        check("haz_set_wins_clear", haz_b, 0);
        step();

        // Reset while busy[3]=1 and in BOOST.
        rb          = 5'd3;
        ld_issue    = 1'b1;
        ld_issue_rc = 5'd3;
        step();
        ld_issue  = 1'b0;
        ld_valid  = 1'b1;
        ld_rc     = 5'd4;
        ld_wd     = 32'h44;
        alu_valid = 1'b1;
        alu_rc    = 5'd6;
        repeat (4) step();
        check("rb_busy3", haz_b, 1);
        check("rb_boost_alu_ready", alu_ready, 1);
        check("rb_werf_pre", werf, 1);
        rst_n = 1'b0;
        #1;
        check("rb_werf", werf, 0);
        check("rb_wa", wa, 0);
        check("rb_wd", wd, 0);
        check("rb_busy_clr", haz_b, 0);
        check("rb_ld_ready", ld_ready, 0);
        check("rb_alu_ready", alu_ready, 0);
        step();
        rst_n = 1'b1;
        step();
        check("rb_first_edge_werf", werf, 0);
        check("rb_norm_ld_ready", ld_ready, 1);
        check("rb_norm_alu_ready", alu_ready, 0);
        step();
        check("rb_after_werf", werf, 1);
        check("rb_after_wa", wa, 4);
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
